// File: rtl/tx_idle_framer.sv
// TX framer for the 8b/10b GT user interface: payload words out, IDLE K-words in every unused or forced slot.
// Latency: one cycle from an accepted data_i to tx_data_o; all outputs registered.
// Backpressure: data_ready_o drops during INIT, on link loss and in the forced slot 0; no skid buffer.
module tx_idle_framer #(
  parameter logic [15:0] g_IDLE        = 16'hbc95,
  parameter int unsigned g_IDLE_PERIOD = 193,
  parameter int unsigned g_INIT_IDLES  = 64
) (
  input  logic        usrclk_i,
  input  logic        rst_n_i,
  input  logic        link_up_i,
  input  logic [15:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [15:0] tx_data_o,
  output logic [1:0]  tx_k_o,
  output logic [31:0] payload_cnt_o,
  output logic [31:0] idle_cnt_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // K28.5 sits in the upper byte of the IDLE word, so only charisk bit 1 is set.
  localparam logic [1:0]  c_K_IDLE    = 2'b10;
  localparam logic [1:0]  c_K_DATA    = 2'b00;
  localparam logic [16:0] c_INIT_LAST = 17'(g_INIT_IDLES - 1);
  localparam logic [15:0] c_SLOT_LAST = 16'(g_IDLE_PERIOD - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_init_cnt;
  logic [15:0] w_init_cnt_nxt;
  logic [15:0] r_slot_cnt;
  logic [15:0] w_slot_cnt_nxt;
  logic [16:0] w_init_inc;
  logic        w_init_done;
  logic        w_accept;

  // INIT ends as the counter steps onto its last value; the slot-0 IDLE that
  // opens RUN then completes the g_INIT_IDLES-long alignment run.
  assign w_init_inc  = {1'b0, r_init_cnt} + 17'd1;
  assign w_init_done = (w_init_inc >= c_INIT_LAST);

  // Link state gates ready combinationally so a dropping link never takes a word.
  assign data_ready_o = (r_state == ST_RUN) && link_up_i && (r_slot_cnt != 16'd0);
  assign w_accept     = data_valid_i && data_ready_o;

  // Next-state logic for the INIT/RUN sequencer and its two counters.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_slot_cnt_nxt = r_slot_cnt;
    case (r_state)
      ST_INIT: begin
        w_slot_cnt_nxt = 16'd0;
        if (!link_up_i) begin
          w_init_cnt_nxt = 16'd0;
        end else if (w_init_done) begin
          w_state_nxt    = ST_RUN;
          w_init_cnt_nxt = 16'd0;
        end else begin
          w_init_cnt_nxt = w_init_inc[15:0];
        end
      end
      ST_RUN: begin
        if (!link_up_i) begin
          w_state_nxt    = ST_INIT;
          w_init_cnt_nxt = 16'd0;
          w_slot_cnt_nxt = 16'd0;
        end else if (r_slot_cnt == c_SLOT_LAST) begin
          w_slot_cnt_nxt = 16'd0;
        end else begin
          w_slot_cnt_nxt = r_slot_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt    = ST_INIT;
        w_init_cnt_nxt = 16'd0;
        w_slot_cnt_nxt = 16'd0;
      end
    endcase
  end

  // Sequencer state and counter registers.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 16'd0;
      r_slot_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_slot_cnt <= w_slot_cnt_nxt;
    end
  end

  // Registered TX word: accepted payload goes out as data, anything else as IDLE; statistics follow the word.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_data_o     <= g_IDLE;
      tx_k_o        <= c_K_IDLE;
      payload_cnt_o <= 32'd0;
      idle_cnt_o    <= 32'd0;
    end else if (w_accept) begin
      tx_data_o     <= data_i;
      tx_k_o        <= c_K_DATA;
      payload_cnt_o <= payload_cnt_o + 32'd1;
    end else begin
      tx_data_o     <= g_IDLE;
      tx_k_o        <= c_K_IDLE;
      idle_cnt_o    <= idle_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_tx_idle_framer.sv
// Bench for tx_idle_framer: directed stimulus, per-cycle expected words queued by the driver, checked by a monitor.
// Main instance uses default parameters; a second instance runs with a period of 2.
// Ready is predicted from consecutive link-up cycles; expected words never come from the DUT.
module tb_tx_idle_framer;

  localparam logic [15:0] IDLE  = 16'hbc95;
  localparam int          P     = 193;
  localparam int          T     = 63;   // link-up edges before the slot-0 IDLE that opens RUN

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  logic [15:0] txd;
  logic [1:0]  txk;
  logic [31:0] pcnt;
  logic [31:0] icnt;

  logic        one = 1'b1;
  logic        ready2;
  logic [15:0] txd2;
  logic [1:0]  txk2;
  logic [31:0] pcnt2;
  logic [31:0] icnt2;
  logic [15:0] d2;
  logic [15:0] data2;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] dq[$];
  logic [1:0]  kq[$];
  int          m_up;
  logic [15:0] cur;
  logic        live = 1'b0;
  int          edges = 0;
  logic [31:0] exp_pcnt;
  logic [31:0] exp_icnt;
  int          idle_before_first;
  bit          seen_first;
  bit          seen_bc95;
  bit          wrap_chk;

  always #5 clk = ~clk;

  tx_idle_framer dut (
    .usrclk_i      (clk),
    .rst_n_i       (rst_n),
    .link_up_i     (link_up),
    .data_i        (data),
    .data_valid_i  (valid),
    .data_ready_o  (ready),
    .tx_data_o     (txd),
    .tx_k_o        (txk),
    .payload_cnt_o (pcnt),
    .idle_cnt_o    (icnt)
  );

  assign data2 = 16'h5A00 + d2;

  tx_idle_framer #(.g_IDLE_PERIOD(2), .g_INIT_IDLES(2)) dut2 (
    .usrclk_i      (clk),
    .rst_n_i       (rst_n),
    .link_up_i     (one),
    .data_i        (data2),
    .data_valid_i  (one),
    .data_ready_o  (ready2),
    .tx_data_o     (txd2),
    .tx_k_o        (txk2),
    .payload_cnt_o (pcnt2),
    .idle_cnt_o    (icnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return link_up && (m_up >= T) && (((m_up - T) % P) != 0);
  endfunction

  // One stimulus cycle; entered and left at posedge+1.
  task automatic cyc(input bit v, input bit l);
    bit exp_rdy;
    valid   = v;
    link_up = l;
    data    = cur;
    @(negedge clk);
    exp_rdy = model_ready();
    chk("data_ready", {31'h0, ready}, {31'h0, exp_rdy});
    if (v && exp_rdy) begin
      dq.push_back(cur);
      kq.push_back(2'b00);
    end else begin
      kq.push_back(2'b10);
    end
    @(posedge clk);
    m_up = l ? m_up + 1 : 0;
    if (v && exp_rdy) cur = cur + 16'd1;
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live  <= 1'b0;
      edges <= 0;
      d2    <= 16'd0;
    end else begin
      live  <= 1'b1;
      edges <= edges + 1;
      if (ready2) d2 <= d2 + 16'd1;
    end
  end

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (rst_n && live) begin
      if (kq.size() == 0) begin
        tests++; fails++;
        $display("FAIL k_queue: output word with no expectation, got k=%b", txk);
      end else begin
        chk("tx_k", {30'h0, txk}, {30'h0, kq.pop_front()});
      end
      if (txk == 2'b00) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL payload_queue: unexpected payload %h", txd);
        end else begin
          chk("payload", {16'h0, txd}, {16'h0, dq.pop_front()});
        end
        exp_pcnt = exp_pcnt + 32'd1;
        chk("payload_cnt", pcnt, exp_pcnt);
        if (!seen_first) begin
          seen_first = 1'b1;
          chk("init_idles", 32'(idle_before_first), 32'd64);
          chk("idle_cnt_at_first", icnt, 32'd64);
        end
        if (txd == IDLE) seen_bc95 = 1'b1;
        if (wrap_chk) begin
          wrap_chk = 1'b0;
          chk("payload_cnt_wrap", pcnt, 32'd0);
        end
      end else begin
        chk("idle_word", {16'h0, txd}, {16'h0, IDLE});
        exp_icnt = exp_icnt + 32'd1;
        chk("idle_cnt", icnt, exp_icnt);
        if (!seen_first) idle_before_first++;
      end
    end
  end

  // Period-2 instance: IDLE at E1 (init) and E2 (slot 0), then payload on every odd edge.
  always @(negedge clk) begin
    if (rst_n && edges >= 1 && edges <= 30) begin
      if (edges >= 3 && (edges % 2) == 1) begin
        chk("p2_k", {30'h0, txk2}, 32'd0);
        chk("p2_data", {16'h0, txd2}, 32'(16'h5A00 + 16'((edges - 3) / 2)));
      end else begin
        chk("p2_k", {30'h0, txk2}, 32'd2);
        chk("p2_idle", {16'h0, txd2}, {16'h0, IDLE});
      end
    end
  end

  task automatic clear_model();
    dq.delete();
    kq.delete();
    m_up              = 0;
    exp_pcnt          = 32'd0;
    exp_icnt          = 32'd0;
    seen_first        = 1'b0;
    idle_before_first = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    link_up   = 1'b1;
    valid     = 1'b0;
    data      = 16'h0;
    cur       = 16'h0;
    seen_bc95 = 1'b0;
    wrap_chk  = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Init run followed by 1000+ cycles of continuous payload.
    for (int i = 0; i < 1100; i++) cyc(1'b1, 1'b1);
    chk("word_sum", pcnt + icnt, 32'(edges));

    // Bubbles 1,0,0,1 across more than one full slot period.
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
    end

    // Payload equal to the IDLE word.
    cur = 16'hbc90;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);

    // Link drop for 5 cycles mid-run, then re-init and resume.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b1);

    // payload counter wrap: preload just below 2^32 after an IDLE word.
    cyc(1'b0, 1'b1);
    force dut.payload_cnt_o = 32'hFFFF_FFFF;
    exp_pcnt = 32'hFFFF_FFFF;
    wrap_chk = 1'b1;
    #1 release dut.payload_cnt_o;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
    chk("wrap_seen", {31'h0, wrap_chk}, 32'd0);

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_tx_data", {16'h0, txd}, {16'h0, IDLE});
    chk("rst_tx_k", {30'h0, txk}, 32'd2);
    chk("rst_ready", {31'h0, ready}, 32'd0);
    chk("rst_payload_cnt", pcnt, 32'd0);
    chk("rst_idle_cnt", icnt, 32'd0);
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1);

    chk("bc95_as_payload", {31'h0, seen_bc95}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
